// File: rtl/ravenoc_pkg.sv
// Shared types and defaults for the RaveNoC router output-port scheduler.
package ravenoc_pkg;

    localparam int NumVirtChn   = 2;
    localparam int CreditsPerVc = 4;

    // Priority orientation: HighPriority puts VC0 on top, ZeroLowPrior puts the top VC on top.
    localparam bit HighPriority = 1'b1;
    localparam bit ZeroLowPrior = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    // Maps a scan position to a VC index so that position 0 is always the highest priority.
    function automatic int prio_idx(input int pos, input int num_vc, input bit zero_high);
        return zero_high ? pos : (num_vc - 1 - pos);
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Per-VC downstream credit counter: saturating up/down with a sticky overflow flag.
module vc_credit_counter
    import ravenoc_pkg::*;
#(
    parameter int CREDITS = CreditsPerVc,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q == CntMax) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            2'b01: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            // A return and a transfer together cancel out.
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= CntMax;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/vc_credit_scheduler.sv
// Credit-based strict-priority VC scheduler with wormhole locking for one router output port.
// Optional performance counters are built when RAVENOC_SCHED_PERF_EN is defined.
module vc_credit_scheduler
    import ravenoc_pkg::*;
#(
    parameter int  NUM_VC         = NumVirtChn,
    parameter int  CREDITS        = CreditsPerVc,
    parameter bit  ZERO_HIGH_PRIO = HighPriority,
    localparam int CNT_W          = $clog2(CREDITS + 1),
    localparam int VC_W           = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [NUM_VC-1:0]       vc_req_i,
    input  logic [NUM_VC-1:0]       vc_head_i,
    input  logic [NUM_VC-1:0]       vc_last_i,
    output logic [NUM_VC-1:0]       vc_gnt_o,
    output logic                    fout_valid_o,
    input  logic                    fout_ready_i,
    input  logic [NUM_VC-1:0]       credit_ret_i,
    output logic [NUM_VC*CNT_W-1:0] credit_cnt_o,
    output logic                    lock_o,
    output logic [VC_W-1:0]         lock_vc_o,
    output logic                    err_o
`ifdef RAVENOC_SCHED_PERF_EN
    ,
    output logic [NUM_VC*32-1:0]    flit_cnt_o,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             nocred_cnt_o
`endif
);

    sched_state_t      state_q, state_d;
    logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
    logic [NUM_VC-1:0] credit_nz, eligible, cand, gnt, xfer, ovf;
    logic [VC_W-1:0]   pick;
    logic              pick_vld;
    logic              valid;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
        vc_credit_counter #(
            .CREDITS (CREDITS),
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .arst_n (arst_n),
            .inc_i  (credit_ret_i[v]),
            .dec_i  (xfer[v]),
            .cnt_o  (credit_cnt_o[v*CNT_W +: CNT_W]),
            .ovf_o  (ovf[v])
        );
        assign credit_nz[v] = |credit_cnt_o[v*CNT_W +: CNT_W];
    end

    assign eligible = vc_req_i & credit_nz;
    assign cand     = eligible & vc_head_i;
    assign xfer     = gnt & {NUM_VC{valid & fout_ready_i}};

    // Scan from highest to lowest priority; the first head-flit candidate wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!pick_vld && cand[prio_idx(i, NUM_VC, ZERO_HIGH_PRIO)]) begin
                pick_vld = 1'b1;
                pick     = VC_W'(prio_idx(i, NUM_VC, ZERO_HIGH_PRIO));
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    // A started-but-unaccepted flit also locks, so grant and valid stay put until the handshake.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        case (state_q)
            IDLE: begin
                if (pick_vld && !(fout_ready_i && vc_last_i[pick])) begin
                    state_d   = LOCKED;
                    lock_vc_d = pick;
                end
            end
            LOCKED: begin
                if ((|xfer) && vc_last_i[lock_vc_q]) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt[pick] = 1'b1;
                    valid     = 1'b1;
                end
            end
            LOCKED: begin
                gnt[lock_vc_q] = 1'b1;
                valid          = eligible[lock_vc_q];
            end
        endcase
    end

    assign vc_gnt_o     = gnt;
    assign fout_valid_o = valid;
    assign lock_o       = (state_q == LOCKED);
    assign lock_vc_o    = lock_vc_q;
    assign err_o        = |ovf;

`ifdef RAVENOC_SCHED_PERF_EN
    logic [31:0] flit_cnt_q [NUM_VC];
    logic [31:0] flit_cnt_d [NUM_VC];
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] nocred_cnt_q, nocred_cnt_d;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            flit_cnt_d[v] = flit_cnt_q[v] + {31'd0, xfer[v]};
        end
        stall_cnt_d  = stall_cnt_q + {31'd0, valid & ~fout_ready_i};
        nocred_cnt_d = nocred_cnt_q + {31'd0, (|(vc_req_i & ~credit_nz)) & ~valid};
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                flit_cnt_q[v] <= '0;
            end
            stall_cnt_q  <= '0;
            nocred_cnt_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                flit_cnt_q[v] <= flit_cnt_d[v];
            end
            stall_cnt_q  <= stall_cnt_d;
            nocred_cnt_q <= nocred_cnt_d;
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_flit_out
        assign flit_cnt_o[v*32 +: 32] = flit_cnt_q[v];
    end
    assign stall_cnt_o  = stall_cnt_q;
    assign nocred_cnt_o = nocred_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vc_credit_scheduler.sv
// Directed bench for vc_credit_scheduler with a transfer scoreboard of expected granted VCs.
module tb_vc_credit_scheduler;

    localparam int NV = 2;
    localparam int CR = 4;
    localparam int CW = $clog2(CR + 1);

    logic           clk = 1'b0;
    logic           arst_n;
    logic [NV-1:0]  vc_req_i, vc_head_i, vc_last_i, credit_ret_i, vc_gnt_o;
    logic           fout_valid_o, fout_ready_i;
    logic [NV*CW-1:0] credit_cnt_o;
    logic           lock_o;
    logic [0:0]     lock_vc_o;
    logic           err_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int sb_q[$];

    always #5 clk = ~clk;

    vc_credit_scheduler dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .vc_req_i     (vc_req_i),
        .vc_head_i    (vc_head_i),
        .vc_last_i    (vc_last_i),
        .vc_gnt_o     (vc_gnt_o),
        .fout_valid_o (fout_valid_o),
        .fout_ready_i (fout_ready_i),
        .credit_ret_i (credit_ret_i),
        .credit_cnt_o (credit_cnt_o),
        .lock_o       (lock_o),
        .lock_vc_o    (lock_vc_o),
        .err_o        (err_o)
    );

    function automatic logic [31:0] cc(input int c1, input int c0);
        logic [CW-1:0] a1, a0;
        a1 = CW'(c1);
        a0 = CW'(c0);
        return 32'({a1, a0});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every accepted flit must match the oldest expected grant.
    task automatic sb_check();
        int e;
        if (fout_valid_o && fout_ready_i) begin
            n_total++;
            assert (sb_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL sb_extra_xfer: observed gnt %0h expected no transfer", vc_gnt_o);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_gnt", 32'(vc_gnt_o), 32'(1 << e));
            end
        end
    endtask

    task automatic drive(input logic [NV-1:0] req, input logic [NV-1:0] head,
                         input logic [NV-1:0] last, input logic rdy,
                         input logic [NV-1:0] ret);
        @(negedge clk);
        vc_req_i     = req;
        vc_head_i    = head;
        vc_last_i    = last;
        fout_ready_i = rdy;
        credit_ret_i = ret;
        #1;
        sb_check();
    endtask

    initial begin
        arst_n       = 1'b0;
        vc_req_i     = '0;
        vc_head_i    = '0;
        vc_last_i    = '0;
        fout_ready_i = 1'b0;
        credit_ret_i = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_credit", 32'(credit_cnt_o), cc(4, 4));
        chk("rst_gnt", 32'(vc_gnt_o), 32'h0);
        chk("rst_valid", 32'(fout_valid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_lock", 32'(lock_o), 32'h0);
        chk("rst_lock_vc", 32'(lock_vc_o), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;

        // Strict priority with single-flit packets until credits run out
        for (int k = 0; k < 8; k++) sb_q.push_back(k < 4 ? 0 : 1);
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 2'b11, 2'b11, 1'b1, 2'b00);
            if (k == 4) chk("prio_vc0_drained", 32'(credit_cnt_o), cc(4, 0));
        end
        drive(2'b11, 2'b11, 2'b11, 1'b1, 2'b00);
        chk("nocred_valid", 32'(fout_valid_o), 32'h0);
        chk("nocred_gnt", 32'(vc_gnt_o), 32'h0);
        chk("nocred_credit", 32'(credit_cnt_o), cc(0, 0));
        for (int k = 0; k < 4; k++) drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b11);

        // Wormhole lock: VC1 3-flit packet blocks VC0
        sb_q.push_back(1);
        drive(2'b10, 2'b10, 2'b00, 1'b1, 2'b00);
        chk("pkt_start_credit", 32'(credit_cnt_o), cc(4, 4));
        chk("pkt_head_gnt", 32'(vc_gnt_o), 32'h2);
        chk("pkt_head_lock", 32'(lock_o), 32'h0);
        sb_q.push_back(1);
        drive(2'b11, 2'b01, 2'b01, 1'b1, 2'b00);
        chk("pkt_body_gnt", 32'(vc_gnt_o), 32'h2);
        chk("pkt_body_lock", 32'(lock_o), 32'h1);
        chk("pkt_lock_vc", 32'(lock_vc_o), 32'h1);
        sb_q.push_back(1);
        drive(2'b11, 2'b01, 2'b11, 1'b1, 2'b00);
        chk("pkt_tail_gnt", 32'(vc_gnt_o), 32'h2);
        chk("pkt_tail_lock", 32'(lock_o), 32'h1);
        sb_q.push_back(0);
        drive(2'b01, 2'b01, 2'b01, 1'b1, 2'b00);
        chk("pkt_after_gnt", 32'(vc_gnt_o), 32'h1);
        chk("pkt_after_lock", 32'(lock_o), 32'h0);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b11);
        chk("pkt_credit", 32'(credit_cnt_o), cc(1, 3));
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b10);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b10);

        // Backpressure: valid and grant hold while ready is low
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 2'b01, 2'b01, 1'b0, 2'b00);
            chk("bp_valid", 32'(fout_valid_o), 32'h1);
            chk("bp_gnt", 32'(vc_gnt_o), 32'h1);
            chk("bp_credit", 32'(credit_cnt_o), cc(4, 4));
        end
        sb_q.push_back(0);
        drive(2'b01, 2'b01, 2'b01, 1'b1, 2'b00);
        chk("bp_accept_credit", 32'(credit_cnt_o), cc(4, 4));
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        chk("bp_after_credit", 32'(credit_cnt_o), cc(4, 3));
        chk("bp_after_lock", 32'(lock_o), 32'h0);

        // Simultaneous transfer and return, then overflow
        sb_q.push_back(0);
        drive(2'b01, 2'b01, 2'b01, 1'b1, 2'b00);
        sb_q.push_back(0);
        drive(2'b01, 2'b01, 2'b01, 1'b1, 2'b01);
        chk("both_pre_credit", 32'(credit_cnt_o), cc(4, 2));
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b01);
        chk("both_credit", 32'(credit_cnt_o), cc(4, 2));
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b01);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b01);
        chk("ovf_pre_credit", 32'(credit_cnt_o), cc(4, 4));
        chk("ovf_pre_err", 32'(err_o), 32'h0);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        chk("ovf_credit", 32'(credit_cnt_o), cc(4, 4));
        chk("ovf_err", 32'(err_o), 32'h1);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        chk("ovf_err_sticky", 32'(err_o), 32'h1);

        // Reset in the middle of a VC1 packet
        sb_q.push_back(1);
        drive(2'b10, 2'b10, 2'b00, 1'b1, 2'b00);
        sb_q.push_back(1);
        drive(2'b10, 2'b00, 2'b00, 1'b1, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        chk("mid_lock", 32'(lock_o), 32'h1);
        chk("mid_credit", 32'(credit_cnt_o), cc(2, 4));
        @(negedge clk);
        vc_req_i  = 2'b10;
        vc_head_i = 2'b00;
        vc_last_i = 2'b00;
        arst_n    = 1'b0;
        #1;
        chk("arst_lock", 32'(lock_o), 32'h0);
        chk("arst_credit", 32'(credit_cnt_o), cc(4, 4));
        chk("arst_err", 32'(err_o), 32'h0);
        chk("arst_valid", 32'(fout_valid_o), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        drive(2'b10, 2'b00, 2'b00, 1'b1, 2'b00);
        chk("post_body_valid", 32'(fout_valid_o), 32'h0);
        chk("post_body_gnt", 32'(vc_gnt_o), 32'h0);
        sb_q.push_back(1);
        drive(2'b10, 2'b10, 2'b10, 1'b1, 2'b00);
        chk("post_head_gnt", 32'(vc_gnt_o), 32'h2);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        chk("post_head_credit", 32'(credit_cnt_o), cc(3, 4));
        chk("post_head_lock", 32'(lock_o), 32'h0);

        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
